// File: rtl/prod_accum.sv
// Windowed saturating accumulator behind the multiplier stage. Sums ACC_LEN signed
// products and holds each window result in a one-entry valid/ready output slot.

module prod_accum_satadd #(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [15:0]      prod,
    output logic [ACC_W-1:0] sum,
    output logic             clamp
);
    logic [ACC_W:0] wide;

    // One guard bit is enough: the product is always narrower than the accumulator.
    always_comb begin
        wide  = {acc[ACC_W-1], acc} + {{(ACC_W-15){prod[15]}}, prod};
        clamp = wide[ACC_W] ^ wide[ACC_W-1];
        if (clamp)
            sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        else
            sum = wide[ACC_W-1:0];
    end
endmodule

module prod_accum #(
    parameter int ACC_LEN = 16,
    parameter int ACC_W   = 24
) (
    input  logic             clk100,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [15:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] sum_out,
    output logic             sum_sat,
    output logic             sum_valid,
    input  logic             sum_ready
);
    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ACC_LEN - 1);

    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             sat_acc;
    logic [ACC_W-1:0] nxt;
    logic             clamp;
    logic             last;
    logic             accept;
    logic             drain;

    prod_accum_satadd #(.ACC_W(ACC_W)) u_add (
        .acc   (acc),
        .prod  (prod_in),
        .sum   (nxt),
        .clamp (clamp)
    );

    assign last  = (cnt == LAST);
    assign drain = sum_valid && sum_ready;

    // Only the closing sample needs the output slot, so only it is stalled.
    assign prod_ready = !clear && !(last && sum_valid && !sum_ready);
    assign accept     = prod_valid && prod_ready;

    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (clear || (accept && last)) begin
            acc     <= '0;
            cnt     <= '0;
            sat_acc <= 1'b0;
        end else if (accept) begin
            acc     <= nxt;
            cnt     <= cnt + 1'b1;
            sat_acc <= sat_acc | clamp;
        end
    end

    // A load in the same cycle as a drain overwrites the slot and keeps it valid.
    always_ff @(posedge clk100 or negedge rst_n) begin
        if (!rst_n) begin
            sum_out   <= '0;
            sum_sat   <= 1'b0;
            sum_valid <= 1'b0;
        end else if (accept && last) begin
            sum_out   <= nxt;
            sum_sat   <= sat_acc | clamp;
            sum_valid <= 1'b1;
        end else if (drain) begin
            sum_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_prod_accum.sv
// Scoreboard bench for prod_accum: directed windows from the test plan, then random
// traffic, checked against a queue-based window model.

module tb_prod_accum;
    localparam int ACC_LEN = 16;
    localparam int ACC_W   = 17;
    localparam longint SMAX = (64'sd1 <<< (ACC_W - 1)) - 1;
    localparam longint SMIN = -(64'sd1 <<< (ACC_W - 1));

    typedef struct {
        longint sum;
        bit     sat;
    } res_t;

    logic             clk100 = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic [15:0]      prod_in = '0;
    logic             prod_valid = 1'b0;
    logic             prod_ready;
    logic [ACC_W-1:0] sum_out;
    logic             sum_sat;
    logic             sum_valid;
    logic             sum_ready = 1'b1;

    int n_chk = 0;
    int n_fail = 0;

    longint win[$];
    res_t   sbq[$];
    res_t   obs[$];

    prod_accum #(.ACC_LEN(ACC_LEN), .ACC_W(ACC_W)) dut (
        .clk100     (clk100),
        .rst_n      (rst_n),
        .clear      (clear),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .sum_out    (sum_out),
        .sum_sat    (sum_sat),
        .sum_valid  (sum_valid),
        .sum_ready  (sum_ready)
    );

    always #5 clk100 = ~clk100;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic res_t window_sum(input longint vals[$]);
        res_t r;
        r.sum = 0;
        r.sat = 0;
        foreach (vals[i]) begin
            r.sum += vals[i];
            if (r.sum > SMAX) begin r.sum = SMAX; r.sat = 1; end
            if (r.sum < SMIN) begin r.sum = SMIN; r.sat = 1; end
        end
        return r;
    endfunction

    // Monitor / model: evaluated mid-cycle while inputs and outputs are stable.
    always @(negedge clk100) begin
        if (!rst_n) begin
            chk("rst_sum_valid", longint'(sum_valid), 0);
            chk("rst_sum_out", longint'($signed(sum_out)), 0);
            chk("rst_sum_sat", longint'(sum_sat), 0);
            chk("rst_prod_ready", longint'(prod_ready), longint'(!clear));
            win.delete();
            sbq.delete();
        end else begin
            bit exp_rdy;
            exp_rdy = !clear && !(win.size() == ACC_LEN - 1 && sbq.size() > 0 && !sum_ready);
            chk("prod_ready", longint'(prod_ready), longint'(exp_rdy));
            chk("sum_valid", longint'(sum_valid), longint'(sbq.size() > 0));
            if (sbq.size() > 0 && sum_ready) begin
                res_t e;
                res_t o;
                e = sbq.pop_front();
                o.sum = longint'($signed(sum_out));
                o.sat = sum_sat;
                chk("sum_out", o.sum, e.sum);
                chk("sum_sat", longint'(o.sat), longint'(e.sat));
                obs.push_back(o);
            end
            if (clear) begin
                win.delete();
            end else if (prod_valid && exp_rdy) begin
                win.push_back(longint'($signed(prod_in)));
                if (win.size() == ACC_LEN) begin
                    sbq.push_back(window_sum(win));
                    win.delete();
                end
            end
        end
    end

    task automatic send(input int v);
        bit ok;
        ok = 0;
        prod_valid = 1'b1;
        prod_in = 16'(v);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk100);
            if (prod_ready) begin ok = 1; break; end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got no accept, expected accept within 100 cycles");
        end
        @(posedge clk100); #1;
        prod_valid = 1'b0;
    endtask

    task automatic send_n(input int n, input int v);
        for (int i = 0; i < n; i++) send(v);
    endtask

    task automatic expect_obs(input string nm, input longint v, input bit s);
        bit got;
        res_t o;
        got = 0;
        for (int i = 0; i < 60; i++) begin
            if (obs.size() > 0) begin got = 1; break; end
            @(posedge clk100); #1;
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got no result, expected %0d", nm, v);
        end else begin
            o = obs.pop_front();
            chk({nm, "_sum"}, o.sum, v);
            chk({nm, "_sat"}, longint'(o.sat), longint'(s));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk100);
        #1;
    endtask

    initial begin
        int v;
        cycles(3);
        rst_n = 1'b1;
        cycles(1);

        // Nominal window
        send_n(16, 100);
        expect_obs("nominal", 1600, 0);
        cycles(2);

        // Mixed signs followed immediately by a second window
        for (int i = 0; i < 8; i++) begin send(-32768); send(32767); end
        send_n(16, 1);
        expect_obs("mixed", -8, 0);
        expect_obs("ones", 16, 0);

        // Saturation in both directions, then a clean window
        send_n(16, 32767);
        send_n(16, -32768);
        send_n(16, 0);
        expect_obs("sat_pos", SMAX, 1);
        expect_obs("sat_neg", SMIN, 1);
        expect_obs("sat_zero", 0, 0);

        // Backpressure: last sample of window 2 stalls until the sink drains
        sum_ready = 1'b0;
        send_n(16, 5);
        send_n(15, 6);
        prod_valid = 1'b1;
        prod_in = 16'(6);
        repeat (3) begin
            @(negedge clk100);
            chk("bp_stall_ready", longint'(prod_ready), 0);
            chk("bp_hold_sum", longint'($signed(sum_out)), 80);
        end
        @(posedge clk100); #1;
        sum_ready = 1'b1;
        @(negedge clk100);
        chk("bp_release_ready", longint'(prod_ready), 1);
        @(posedge clk100); #1;
        prod_valid = 1'b0;
        expect_obs("bp_w1", 80, 0);
        expect_obs("bp_w2", 96, 0);

        // Clear aborts a partial window
        send_n(5, 7);
        clear = 1'b1;
        cycles(1);
        clear = 1'b0;
        send_n(16, 3);
        expect_obs("clear", 48, 0);

        // Clear while a result is pending leaves it intact
        sum_ready = 1'b0;
        send_n(16, 4);
        send_n(2, 4);
        clear = 1'b1;
        @(negedge clk100);
        chk("clear_pend_ready", longint'(prod_ready), 0);
        @(posedge clk100); #1;
        clear = 1'b0;
        @(negedge clk100);
        chk("clear_pend_valid", longint'(sum_valid), 1);
        chk("clear_pend_sum", longint'($signed(sum_out)), 64);
        @(posedge clk100); #1;
        sum_ready = 1'b1;
        expect_obs("clear_pend", 64, 0);
        send_n(16, 1);
        expect_obs("after_clear", 16, 0);

        // Asynchronous reset mid-window with a result pending
        sum_ready = 1'b0;
        send_n(16, 1);
        send_n(9, 2);
        @(posedge clk100); #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", longint'(sum_valid), 0);
        chk("async_rst_sum", longint'($signed(sum_out)), 0);
        chk("async_rst_ready", longint'(prod_ready), 1);
        cycles(2);
        rst_n = 1'b1;
        sum_ready = 1'b1;
        send_n(16, 2);
        expect_obs("post_rst", 32, 0);

        // Random traffic; the scoreboard carries the checking
        for (int c = 0; c < 1500; c++) begin
            prod_valid = ($urandom_range(0, 99) < 75);
            case ($urandom_range(0, 3))
                0: v = -32768;
                1: v = 32767;
                default: v = int'($signed(16'($urandom)));
            endcase
            prod_in = 16'(v);
            sum_ready = ($urandom_range(0, 99) < 60);
            clear = ($urandom_range(0, 99) < 2);
            cycles(1);
        end
        prod_valid = 1'b0;
        clear = 1'b0;
        sum_ready = 1'b1;
        cycles(4);
        chk("final_drained", longint'(sbq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
